// File: rtl/barcode_rx.sv
// Barcode serial receiver. It measures the start-bit low time T and then samples
// each data bit T clocks after that bit's falling edge, MSB first.
module barcode_rx #(
  parameter int          ID_W     = 8,
  parameter int          TMR_W    = 22,
  parameter int          PREFIX_W = 2,
  parameter int unsigned PREFIX   = 0,
  parameter int          TO_MULT  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            BC,
  input  logic            clr_ID_vld,
  output logic [ID_W-1:0] ID,
  output logic            ID_vld,
  output logic            frame_err,
  output logic            busy
);

  localparam int CNT_W = TMR_W + 3;
  localparam int BIT_W = $clog2(ID_W + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_FALL, SAMPLE, CHECK} state_t;

  state_t             state_q, state_d;
  logic               bcMeta_q, bcS_q, bcD_q;
  logic               fall;
  logic [TMR_W-1:0]   per_q, per_d;
  logic [TMR_W-1:0]   tPer_q, tPer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   toLimit;
  logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [ID_W-1:0]    shreg_q, shreg_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               vld_q, vld_d;
  logic               prefixOk, cntAtT, setVld;

  // Synchroniser and edge flops idle high so that leaving reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcMeta_q <= 1'b1;
      bcS_q    <= 1'b1;
      bcD_q    <= 1'b1;
    end else begin
      bcMeta_q <= BC;
      bcS_q    <= bcMeta_q;
      bcD_q    <= bcS_q;
    end
  end

  assign fall    = bcD_q & ~bcS_q;
  assign toLimit = CNT_W'(TO_MULT) * CNT_W'(tPer_q);
  assign cntAtT  = (cnt_q == CNT_W'(tPer_q));

  generate
    if (PREFIX_W == 0) begin : gNoPrefix
      assign prefixOk = 1'b1;
    end else begin : gPrefix
      assign prefixOk = (shreg_q[ID_W-1 -: PREFIX_W] == PREFIX_W'(PREFIX));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      per_q    <= '0;
      tPer_q   <= '0;
      cnt_q    <= '0;
      bitCnt_q <= '0;
      shreg_q  <= '0;
      id_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      tPer_q   <= tPer_d;
      cnt_q    <= cnt_d;
      bitCnt_q <= bitCnt_d;
      shreg_q  <= shreg_d;
      id_q     <= id_d;
      vld_q    <= vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    tPer_d    = tPer_q;
    cnt_d     = cnt_q;
    bitCnt_d  = bitCnt_q;
    shreg_d   = shreg_q;
    frame_err = 1'b0;
    setVld    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d  = START;
          per_d    = TMR_W'(1);
          bitCnt_d = '0;
          shreg_d  = '0;
        end
      end
      START: begin
        if (bcS_q) begin
          tPer_d  = per_q;
          cnt_d   = '0;
          state_d = WAIT_FALL;
        end else if (per_q == '1) begin
          frame_err = 1'b1;
          state_d   = IDLE;
        end else begin
          per_d = per_q + TMR_W'(1);
        end
      end
      WAIT_FALL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall) begin
          cnt_d   = CNT_W'(1);
          state_d = SAMPLE;
        end else if (cnt_q == toLimit) begin
          frame_err = 1'b1;
          state_d   = IDLE;
        end
      end
      SAMPLE: begin
        // Falls inside the sampling window are deliberately ignored; only the count matters here.
        if (cntAtT) begin
          shreg_d  = {shreg_q[ID_W-2:0], bcS_q};
          bitCnt_d = bitCnt_q + BIT_W'(1);
          if (bitCnt_q == BIT_W'(ID_W - 1)) begin
            state_d = CHECK;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_FALL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (prefixOk) setVld = 1'b1;
        else          frame_err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A good frame and an acknowledge in the same cycle leave the flag set.
  assign vld_d = setVld | (vld_q & ~clr_ID_vld);
  assign id_d  = setVld ? shreg_q : id_q;

  assign ID     = id_q;
  assign ID_vld = vld_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_barcode_rx.sv
// Self-checking bench for barcode_rx: directed and random frames on an 8-bit and a
// 12-bit receiver, checked against frame timing derived from the line protocol.
module tb_barcode_rx;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        bc8   = 1'b1, clr8  = 1'b0;
  logic        bc12  = 1'b1, clr12 = 1'b0;
  logic [7:0]  id8;
  logic        vld8, err8, busy8;
  logic [11:0] id12;
  logic        vld12, err12, busy12;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int errCyc8[$], errCyc12[$], rise8[$], rise12[$];
  logic prevVld8 = 1'b0, prevVld12 = 1'b0;

  int          mdlT, mdlLastFall;
  logic [31:0] mdlBits;

  barcode_rx dut8 (
    .clk(clk), .rst_n(rst_n), .BC(bc8), .clr_ID_vld(clr8),
    .ID(id8), .ID_vld(vld8), .frame_err(err8), .busy(busy8)
  );

  barcode_rx #(.ID_W(12), .PREFIX_W(4), .PREFIX(4'hA)) dut12 (
    .clk(clk), .rst_n(rst_n), .BC(bc12), .clr_ID_vld(clr12),
    .ID(id12), .ID_vld(vld12), .frame_err(err12), .busy(busy12)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log: the cycle of every frame_err pulse and every ID_vld rising edge.
  always @(negedge clk) begin
    if (err8 === 1'b1) errCyc8.push_back(cyc);
    if (vld8 === 1'b1 && prevVld8 !== 1'b1) rise8.push_back(cyc);
    prevVld8 = vld8;
    if (err12 === 1'b1) errCyc12.push_back(cyc);
    if (vld12 === 1'b1 && prevVld12 !== 1'b1) rise12.push_back(cyc);
    prevVld12 = vld12;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bc8 = 1'b1; bc12 = 1'b1; clr8 = 1'b0; clr12 = 1'b0;
    end
  endtask

  // Plays one frame: start low T, high T, then 3T cells ('1' low T/2, '0' low 2T).
  // The model bits come from the low durations: a bit reads 1 when the line is high again by T.
  task automatic applyStimulus(input bit sel, input int tPer, input int nBits,
                               input logic [31:0] data, input int nSend, input bit clrAtCheck);
    bit          wave[$];
    int          rel[$];
    int          f0, clrCyc;
    logic [31:0] bits;
    bits   = '0;
    clrCyc = -1;
    f0     = 0;
    for (int j = 0; j < tPer; j++) wave.push_back(1'b0);
    for (int j = 0; j < tPer; j++) wave.push_back(1'b1);
    for (int i = 0; i < nSend; i++) begin
      int low;
      low = data[nBits-1-i] ? tPer / 2 : 2 * tPer;
      rel.push_back(wave.size());
      for (int j = 0; j < low; j++) wave.push_back(1'b0);
      for (int j = 0; j < 3 * tPer - low; j++) wave.push_back(1'b1);
      bits = {bits[30:0], (low <= tPer)};
    end
    for (int k = 0; k < wave.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        f0 = cyc + 1;
        if (clrAtCheck) clrCyc = f0 + rel[nSend-1] + tPer + 2;
      end
      if (sel) begin bc12 = wave[k]; clr12 = (cyc == clrCyc); end
      else     begin bc8  = wave[k]; clr8  = (cyc == clrCyc); end
    end
    mdlT        = tPer;
    mdlLastFall = f0 + rel[nSend-1];
    mdlBits     = bits;
  endtask

  task automatic snapshot(input bit sel, output int errB, output int riseB,
                          output logic vldB, output logic [31:0] idB);
    if (sel) begin
      errB = errCyc12.size(); riseB = rise12.size(); vldB = vld12; idB = 32'(id12);
    end else begin
      errB = errCyc8.size();  riseB = rise8.size();  vldB = vld8;  idB = 32'(id8);
    end
  endtask

  // Expected outcome of a complete frame: prefix decides accept/reject; CHECK sits T+2
  // cycles after the last fall is presented, and ID_vld rises one cycle later.
  task automatic checkFrame(input bit sel, input string tag, input int nBits, input int prefixW,
                            input logic [31:0] prefixVal, input int errB, input int riseB,
                            input logic vldB, input logic [31:0] idB);
    bit          good;
    int          errNow, riseNow, lastErr, lastRise;
    logic [31:0] obsId;
    logic        obsVld, obsBusy;
    good = (prefixW == 0) || ((mdlBits >> (nBits - prefixW)) == prefixVal);
    if (sel) begin
      errNow = errCyc12.size(); riseNow = rise12.size();
      lastErr  = (errNow > 0)  ? errCyc12[errNow-1] : -1;
      lastRise = (riseNow > 0) ? rise12[riseNow-1]  : -1;
      obsId = 32'(id12); obsVld = vld12; obsBusy = busy12;
    end else begin
      errNow = errCyc8.size(); riseNow = rise8.size();
      lastErr  = (errNow > 0)  ? errCyc8[errNow-1] : -1;
      lastRise = (riseNow > 0) ? rise8[riseNow-1]  : -1;
      obsId = 32'(id8); obsVld = vld8; obsBusy = busy8;
    end
    checkOutput({tag, " ID"}, obsId, good ? mdlBits : idB);
    checkOutput({tag, " ID_vld"}, 32'(obsVld), 32'(good | vldB));
    checkOutput({tag, " err count"}, errNow - errB, good ? 0 : 1);
    if (!good) checkOutput({tag, " err cycle"}, lastErr, mdlLastFall + mdlT + 2);
    checkOutput({tag, " vld rises"}, riseNow - riseB, (good && !vldB) ? 1 : 0);
    if (good && !vldB) checkOutput({tag, " vld rise cycle"}, lastRise, mdlLastFall + mdlT + 3);
    checkOutput({tag, " busy"}, 32'(obsBusy), 0);
  endtask

  initial begin
    int          eB, rB;
    logic        vB;
    logic [31:0] iB;

    repeat (3) @(negedge clk);
    checkOutput("reset ID", 32'(id8), 0);
    checkOutput("reset ID_vld", 32'(vld8), 0);
    checkOutput("reset frame_err", 32'(err8), 0);
    checkOutput("reset busy", 32'(busy8), 0);
    rst_n = 1'b1;
    idle(5);

    $display("[TB] frame 0x2A, T=100");
    snapshot(0, eB, rB, vB, iB);
    applyStimulus(0, 100, 8, 32'h2A, 8, 0);
    idle(4);
    checkFrame(0, "f2A", 8, 2, 0, eB, rB, vB, iB);

    $display("[TB] frame 0xC5, bad prefix");
    snapshot(0, eB, rB, vB, iB);
    applyStimulus(0, 100, 8, 32'hC5, 8, 0);
    idle(4);
    checkFrame(0, "fC5", 8, 2, 0, eB, rB, vB, iB);

    $display("[TB] inter-bit timeout after 3 bits");
    snapshot(0, eB, rB, vB, iB);
    applyStimulus(0, 100, 8, 32'h2A, 3, 0);
    checkOutput("timeout busy mid-frame", 32'(busy8), 1);
    idle(520);
    checkOutput("timeout err count", errCyc8.size() - eB, 1);
    checkOutput("timeout err cycle", errCyc8[errCyc8.size()-1], mdlLastFall + 2 + 5 * mdlT);
    checkOutput("timeout busy", 32'(busy8), 0);
    checkOutput("timeout ID held", 32'(id8), iB);
    checkOutput("timeout ID_vld held", 32'(vld8), 32'(vB));
    snapshot(0, eB, rB, vB, iB);
    applyStimulus(0, $urandom_range(60, 8), 8, 32'($urandom_range(63, 0)), 8, 0);
    idle(4);
    checkFrame(0, "after timeout", 8, 2, 0, eB, rB, vB, iB);

    $display("[TB] clr_ID_vld during CHECK of 0x15");
    snapshot(0, eB, rB, vB, iB);
    applyStimulus(0, 100, 8, 32'h15, 8, 1);
    idle(4);
    checkFrame(0, "f15 clr", 8, 2, 0, eB, rB, vB, iB);
    @(negedge clk);
    checkOutput("pre-clear ID_vld", 32'(vld8), 1);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    checkOutput("clear ID_vld", 32'(vld8), 0);
    checkOutput("clear keeps ID", 32'(id8), 32'h15);

    $display("[TB] random frames");
    for (int r = 0; r < 4; r++) begin
      int          tr;
      logic [31:0] d;
      tr = $urandom_range(60, 8);
      d  = 32'($urandom_range(255, 0));
      if ($urandom_range(1, 0) == 1) d[7:6] = 2'b00;
      snapshot(0, eB, rB, vB, iB);
      applyStimulus(0, tr, 8, d, 8, 0);
      idle(4);
      checkFrame(0, $sformatf("rand%0d", r), 8, 2, 0, eB, rB, vB, iB);
    end

    $display("[TB] reset mid-frame, then 0x3C");
    snapshot(0, eB, rB, vB, iB);
    applyStimulus(0, 100, 8, 32'h3C, 4, 0);
    checkOutput("mid-frame busy", 32'(busy8), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid reset ID", 32'(id8), 0);
    checkOutput("mid reset ID_vld", 32'(vld8), 0);
    checkOutput("mid reset frame_err", 32'(err8), 0);
    checkOutput("mid reset busy", 32'(busy8), 0);
    idle(3);
    rst_n = 1'b1;
    idle(600);
    checkOutput("mid reset err count", errCyc8.size() - eB, 0);
    snapshot(0, eB, rB, vB, iB);
    applyStimulus(0, 100, 8, 32'h3C, 8, 0);
    idle(4);
    checkFrame(0, "f3C", 8, 2, 0, eB, rB, vB, iB);

    $display("[TB] 12-bit receiver, prefix 0xA, T=37");
    snapshot(1, eB, rB, vB, iB);
    applyStimulus(1, 37, 12, 32'hA5C, 12, 0);
    idle(4);
    checkFrame(1, "fA5C", 12, 4, 32'hA, eB, rB, vB, iB);
    snapshot(1, eB, rB, vB, iB);
    applyStimulus(1, 37, 12, 32'hB5C, 12, 0);
    idle(4);
    checkFrame(1, "fB5C", 12, 4, 32'hA, eB, rB, vB, iB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
